// File: rtl/boton_pkg.sv
// Shared button-chain definitions: FSM state encodings and default timing.
package boton_pkg;

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } state_t;

    localparam int unsigned DEF_LONG_TIME   = 50000000;
    localparam int unsigned DEF_REPEAT_TIME = 12500000;

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/boton_eventos_if.sv
// Debounced button level in, single-cycle event strobes and held level out.
interface boton_eventos_if;
    logic btn_in;
    logic short_press;
    logic long_press;
    logic repeat_press;
    logic held;

    modport master (
        output btn_in,
        input  short_press,
        input  long_press,
        input  repeat_press,
        input  held
    );

    modport slave (
        input  btn_in,
        output short_press,
        output long_press,
        output repeat_press,
        output held
    );
endinterface

// File: rtl/boton_eventos.sv
// Turns a debounced button level into short/long/repeat event pulses.
module boton_eventos
    import boton_pkg::*;
#(
    parameter int unsigned LONG_TIME   = DEF_LONG_TIME,
    parameter int unsigned REPEAT_TIME = DEF_REPEAT_TIME,
    parameter bit          REPEAT_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    boton_eventos_if.slave  bus
);

    localparam int unsigned CW = cnt_width(LONG_TIME, REPEAT_TIME);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TIME - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TIME - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_short;
    logic          r_long;
    logic          r_rep;
    logic          r_held;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOCKOUT;
            r_cnt   <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
            unique case (r_state)
                // A level still high out of reset must be released first
                ST_LOCKOUT: begin
                    r_cnt <= '0;
                    if (!bus.btn_in) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.btn_in) begin
                        r_state <= ST_PRESSED;
                        r_held  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!bus.btn_in) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                        r_short <= 1'b1;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!bus.btn_in) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else if (r_cnt == REP_LAST) begin
                        r_cnt <= '0;
                        r_rep <= REPEAT_EN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.short_press  = r_short;
    assign bus.long_press   = r_long;
    assign bus.repeat_press = r_rep;
    assign bus.held         = r_held;

endmodule

// File: tb/tb_boton_eventos.sv
// Scoreboard bench: stimulus queues expected strobes, monitor pops on each one.
module tb_boton_eventos;

    localparam int K_SHORT = 0;
    localparam int K_LONG  = 1;
    localparam int K_REP   = 2;
    localparam int K0_SHORT = 3;
    localparam int K0_LONG  = 4;
    localparam int K0_REP   = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];

    boton_eventos_if bus ();
    boton_eventos_if bus0 ();

    boton_eventos #(
        .LONG_TIME   (8),
        .REPEAT_TIME (4),
        .REPEAT_EN   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    boton_eventos #(
        .LONG_TIME   (8),
        .REPEAT_TIME (4),
        .REPEAT_EN   (1'b0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0b want %0b", name, cyc, act, exp);
        end
    endtask

    task automatic pulse_seen(input logic p, input int k);
        ev_t e;
        if (p === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d", k, cyc);
            end else begin
                e = q.pop_front();
                if (e.kind != k || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                             k, cyc, e.kind, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        pulse_seen(bus.short_press, K_SHORT);
        pulse_seen(bus.long_press, K_LONG);
        pulse_seen(bus.repeat_press, K_REP);
        pulse_seen(bus0.short_press, K0_SHORT);
        pulse_seen(bus0.long_press, K0_LONG);
        pulse_seen(bus0.repeat_press, K0_REP);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int k, input int off);
        q.push_back('{k, cyc + off});
    endtask

    task automatic press_for(input int n);
        bus.btn_in = 1'b1;
        step(n);
        bus.btn_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.btn_in = 1'b0;
        bus0.btn_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_short", bus.short_press, 1'b0);
        chk("rst_long", bus.long_press, 1'b0);
        chk("rst_rep", bus.repeat_press, 1'b0);
        chk("rst_held", bus.held, 1'b0);
        chk("rst_held0", bus0.held, 1'b0);
        step(1);
        reset = 1'b1;

        // short press, 3 cycles high
        step(2);
        expect_ev(K_SHORT, 4);
        bus.btn_in = 1'b1;
        step(1);
        @(negedge clk);
        chk("short_held_first", bus.held, 1'b1);
        step(2);
        bus.btn_in = 1'b0;
        @(negedge clk);
        chk("short_held_last", bus.held, 1'b1);
        step(1);
        @(negedge clk);
        chk("short_held_drop", bus.held, 1'b0);
        step(3);

        // long press with repeats; release on repeat terminal is silent
        expect_ev(K_LONG, 9);
        expect_ev(K_REP, 13);
        expect_ev(K_REP, 17);
        press_for(20);
        @(negedge clk);
        chk("long_held", bus.held, 1'b1);
        step(1);
        @(negedge clk);
        chk("long_release_held", bus.held, 1'b0);
        step(4);

        // boundary: release on the terminal-count sample
        expect_ev(K_SHORT, 9);
        press_for(8);
        step(3);
        // one more cycle high reaches long press
        expect_ev(K_LONG, 9);
        press_for(9);
        step(4);

        // minimum press and back-to-back re-arm
        expect_ev(K_SHORT, 2);
        press_for(1);
        step(1);
        expect_ev(K_SHORT, 2);
        press_for(1);
        step(3);

        // held through reset
        reset = 1'b0;
        bus.btn_in = 1'b1;
        step(2);
        reset = 1'b1;
        step(12);
        @(negedge clk);
        chk("lockout_held", bus.held, 1'b0);
        step(1);
        bus.btn_in = 1'b0;
        step(1);
        expect_ev(K_SHORT, 3);
        press_for(2);
        step(3);

        // reset mid-hold
        bus.btn_in = 1'b1;
        step(5);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_held", bus.held, 1'b0);
        chk("midrst_short", bus.short_press, 1'b0);
        chk("midrst_long", bus.long_press, 1'b0);
        chk("midrst_rep", bus.repeat_press, 1'b0);
        step(12);
        @(negedge clk);
        chk("midrst_lock_held", bus.held, 1'b0);
        step(1);
        bus.btn_in = 1'b0;
        step(2);
        expect_ev(K_SHORT, 3);
        press_for(2);
        step(3);

        // repeat disabled instance
        expect_ev(K0_LONG, 9);
        bus0.btn_in = 1'b1;
        step(20);
        bus0.btn_in = 1'b0;
        step(6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got %0d pending want 0 (next kind=%0d cyc=%0d)",
                     q.size(), q[0].kind, q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
